// File: rtl/framebuffer_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_pkg
//
// Shared definitions for the LED-panel framebuffer write and read paths.
//   - Panel geometry: 2 halves x 16 rows x 64 columns = 2048 pixels.
//   - RAM geometry: 11-bit word address, 16-bit RGB565 word.
//   - Write-side FSM state encoding.
//   - Helper to swap the red and blue fields of an RGB565 word.
// -----------------------------------------------------------------------------
package framebuffer_pkg;

  // Panel geometry
  localparam int COLUMNS       = 64;
  localparam int ROWS_PER_HALF = 16;
  localparam int HALVES        = 2;
  localparam int PIXEL_COUNT   = HALVES * ROWS_PER_HALF * COLUMNS;

  // Field widths of a pixel index: {half, row, column}
  localparam int COLUMN_W = $clog2(COLUMNS);
  localparam int ROW_W    = $clog2(ROWS_PER_HALF);

  // RAM geometry
  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 16;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  // Byte-assembly FSM: wait for a frame, collect high byte, collect low
  // byte, then spend one cycle strobing the RAM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    WRITE = 2'd3
  } fb_state_t;

  // RGB565 {r[4:0], g[5:0], b[4:0]} -> {b[4:0], g[5:0], r[4:0]}
  function automatic ram_data_t swap_red_blue(input ram_data_t pixel);
    return {pixel[4:0], pixel[10:5], pixel[15:11]};
  endfunction

endpackage

// File: rtl/framebuffer_address_map.sv
// -----------------------------------------------------------------------------
// framebuffer_address_map
//
// Combinational mapping from a linear pixel index to the panel RAM address.
// The index is {y[4:0], x[5:0]}; y[4] selects the panel half, y[3:0] the row
// within that half. Columns are stored mirrored because the panel shifts the
// last column in first, so the address is {half, row, ~x}. Shared by the write
// and read sides so both agree on the layout.
//
// Ports
//   pixel_index  in   11  linear pixel index p
//   ram_address  out  11  {y[4], y[3:0], ~x}
// -----------------------------------------------------------------------------
module framebuffer_address_map
  import framebuffer_pkg::*;
(
  input  logic [RAM_ADDR_W-1:0] pixel_index,
  output logic [RAM_ADDR_W-1:0] ram_address
);

  logic                half;
  logic [ROW_W-1:0]    row;
  logic [COLUMN_W-1:0] column;

  assign column = pixel_index[COLUMN_W-1:0];
  assign row    = pixel_index[COLUMN_W +: ROW_W];
  assign half   = pixel_index[COLUMN_W + ROW_W];

  assign ram_address = {half, row, ~column};

endmodule

// File: rtl/framebuffer_write.sv
// -----------------------------------------------------------------------------
// framebuffer_write
//
// Assembles an RGB565 byte stream (high byte first) into 16-bit pixels and
// writes them into the panel framebuffer RAM, one pixel per three cycles at
// best. Bytes move on a valid/ready handshake. frame_start restarts the frame
// at pixel 0 from any state; frame_done pulses once after the final pixel of a
// frame has been written.
//
// Build option
//   FRAMEBUFFER_WRITE_BGR_SWAP_EN  when defined, red and blue fields are
//                                  swapped before the RAM write. Timing is the
//                                  same in both builds.
//
// Ports
//   reset             in   1   asynchronous, active-high reset
//   clk_in            in   1   system clock, rising edge
//   frame_start       in   1   one-cycle pulse, restart at pixel 0
//   data_in           in   8   RGB565 byte stream, high byte first
//   data_valid        in   1   data_in holds a valid byte
//   data_ready        out  1   a byte is accepted this cycle if valid
//   ram_address       out  11  {half, row[3:0], ~column[5:0]}
//   ram_data_out      out  16  pixel written to RAM
//   ram_write_enable  out  1   one-cycle write strobe
//   ram_clk_enable    out  1   RAM clock enable, follows the write strobe
//   frame_done        out  1   one-cycle pulse after the last pixel write
// -----------------------------------------------------------------------------
module framebuffer_write #(
  parameter int PIXEL_COUNT = 2048
) (
  input  logic        reset,
  input  logic        clk_in,
  input  logic        frame_start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [10:0] ram_address,
  output logic [15:0] ram_data_out,
  output logic        ram_write_enable,
  output logic        ram_clk_enable,
  output logic        frame_done
);

  import framebuffer_pkg::*;

  localparam ram_addr_t LAST_PIXEL = RAM_ADDR_W'(PIXEL_COUNT - 1);

  fb_state_t state;
  fb_state_t state_next;

  ram_addr_t pixel_index;
  ram_addr_t mapped_address;
  logic [7:0] hi_byte;
  ram_data_t assembled;
  ram_data_t formatted;

  // Control strobes decoded by the FSM
  logic hi_load;        // capture high byte
  logic lo_load;        // capture low byte, launch the RAM write
  logic index_advance;  // move to the next pixel after a write
  logic index_clear;    // restart at pixel 0
  logic frame_end;      // last pixel of the frame has just been written

  // ---------------------------------------------------------------------------
  // Pixel formatting
  // ---------------------------------------------------------------------------
  assign assembled = {hi_byte, data_in};

`ifdef FRAMEBUFFER_WRITE_BGR_SWAP_EN
  assign formatted = swap_red_blue(assembled);
`else
  assign formatted = assembled;
`endif

  framebuffer_address_map u_address_map (
    .pixel_index (pixel_index),
    .ram_address (mapped_address)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_next    = state;
    data_ready    = 1'b0;
    hi_load       = 1'b0;
    lo_load       = 1'b0;
    index_advance = 1'b0;
    index_clear   = 1'b0;
    frame_end     = 1'b0;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end

      HI: begin
        data_ready = 1'b1;
        if (data_valid) begin
          hi_load    = 1'b1;
          state_next = LO;
        end
      end

      LO: begin
        data_ready = 1'b1;
        if (data_valid) begin
          lo_load    = 1'b1;
          state_next = WRITE;
        end
      end

      WRITE: begin
        if (pixel_index == LAST_PIXEL) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end else begin
          index_advance = 1'b1;
          state_next    = HI;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A restart overrides everything: any half-built pixel and any byte
    // handed over this cycle are dropped. A write already on the RAM port
    // this cycle is not cancelled (the strobe is decoded from state), but it
    // neither advances the index nor ends the frame.
    if (frame_start) begin
      state_next    = HI;
      hi_load       = 1'b0;
      lo_load       = 1'b0;
      index_advance = 1'b0;
      frame_end     = 1'b0;
      index_clear   = 1'b1;
    end
  end

  // The RAM strobe and its clock enable are the WRITE state itself, so they
  // are glitch-free and drop together with the state on reset.
  assign ram_write_enable = (state == WRITE);
  assign ram_clk_enable   = (state == WRITE);

  // ---------------------------------------------------------------------------
  // Datapath: pixel index, byte capture, RAM port registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset too, not just the control state,
  // because address and data are visible outputs that must read zero while
  // reset is held.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pixel_index  <= '0;
      hi_byte      <= '0;
      ram_address  <= '0;
      ram_data_out <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= frame_end;

      if (index_clear || frame_end) begin
        pixel_index <= '0;
      end else if (index_advance) begin
        pixel_index <= pixel_index + 11'd1;
      end

      if (hi_load) begin
        hi_byte <= data_in;
      end

      // Address and data are registered on the low-byte transfer so they
      // stay stable for the whole WRITE cycle that follows.
      if (lo_load) begin
        ram_address  <= mapped_address;
        ram_data_out <= formatted;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_write.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_write
//
// Self-checking bench for framebuffer_write. A transaction-level model tracks
// frame activity, the pending high byte and the current pixel number, and
// predicts each cycle's outputs; one compare process checks the DUT against it
// on every falling edge. Directed sequences pin the model with hand-computed
// literals (first write, full frame, mirrored addresses, restart, reset during
// a write), then a randomized phase exercises handshakes, restarts and resets.
// Build with FRAMEBUFFER_WRITE_BGR_SWAP_EN to check the swapped-colour build.
// -----------------------------------------------------------------------------
module tb_framebuffer_write;

  localparam int PIXELS = 2048;

  logic        reset;
  logic        clk_in;
  logic        frame_start;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [10:0] ram_address;
  logic [15:0] ram_data_out;
  logic        ram_write_enable;
  logic        ram_clk_enable;
  logic        frame_done;

  framebuffer_write #(.PIXEL_COUNT(PIXELS)) dut (
    .reset            (reset),
    .clk_in           (clk_in),
    .frame_start      (frame_start),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .frame_done       (frame_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  // Pixel p sits at column p%64 of line p/64; columns are stored mirrored.
  function automatic int exp_addr(input int p);
    return (p / 64) * 64 + (63 - (p % 64));
  endfunction

  function automatic int exp_pixel(input int hi, input int lo);
    int pix;
    int r;
    int g;
    int b;
    pix = hi * 256 + lo;
    r = pix / 2048;
    g = (pix / 32) % 64;
    b = pix % 32;
`ifdef FRAMEBUFFER_WRITE_BGR_SWAP_EN
    return b * 2048 + g * 32 + r;
`else
    return r * 2048 + g * 32 + b;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: frame activity, pending high byte, pixel number, and
  // whether this cycle is the RAM write of an assembled pixel.
  // ---------------------------------------------------------------------------
  bit m_active  = 0;
  bit m_hi_held = 0;
  bit m_wr      = 0;
  bit m_done    = 0;
  int m_p       = 0;
  int m_hi      = 0;
  int m_addr    = 0;
  int m_data    = 0;

  always @(posedge clk_in or posedge reset) begin
    bit acc;
    if (reset) begin
      m_active  = 0;
      m_hi_held = 0;
      m_wr      = 0;
      m_done    = 0;
      m_p       = 0;
    end else begin
      acc    = data_valid && m_active && !m_wr;
      m_done = 0;
      if (frame_start) begin
        m_active  = 1;
        m_hi_held = 0;
        m_wr      = 0;
        m_p       = 0;
      end else if (m_wr) begin
        m_wr = 0;
        if (m_p == PIXELS - 1) begin
          m_p      = 0;
          m_active = 0;
          m_done   = 1;
        end else begin
          m_p = m_p + 1;
        end
      end else if (acc) begin
        if (!m_hi_held) begin
          m_hi      = int'(data_in);
          m_hi_held = 1;
        end else begin
          m_wr      = 1;
          m_addr    = exp_addr(m_p);
          m_data    = exp_pixel(m_hi, int'(data_in));
          m_hi_held = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and observation log
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          dut_wcount = 0;
  int          frame_widx = 0;
  int          last_we_cyc = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  logic [10:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [10:0] addr_log [4096];
  logic [15:0] dut_ram  [PIXELS];
  logic [15:0] ram_cont [PIXELS];

  always @(negedge clk_in) begin
    cyc++;
    if (reset) begin
      check("rst_data_ready", data_ready, 0);
      check("rst_write_enable", ram_write_enable, 0);
      check("rst_clk_enable", ram_clk_enable, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_ram_address", ram_address, 0);
      check("rst_ram_data_out", ram_data_out, 0);
    end else begin
      check("data_ready", data_ready, m_active && !m_wr);
      check("ram_write_enable", ram_write_enable, m_wr);
      check("ram_clk_enable", ram_clk_enable, m_wr);
      check("frame_done", frame_done, m_done);
      if (m_wr) begin
        check("ram_address", ram_address, m_addr);
        check("ram_data_out", ram_data_out, m_data);
      end
      if (ram_write_enable) begin
        dut_ram[ram_address] = ram_data_out;
        if (frame_widx < 4096) addr_log[frame_widx] = ram_address;
        frame_widx++;
        dut_wcount++;
        last_addr   = ram_address;
        last_data   = ram_data_out;
        last_we_cyc = cyc;
      end
      if (frame_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (frame_start) frame_widx = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  logic [7:0] tx_bytes [4096];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid  = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_frame_start(input bit with_valid, input logic [7:0] d);
    frame_start = 1'b1;
    data_valid  = with_valid;
    data_in     = d;
    tick();
    frame_start = 1'b0;
    data_valid  = 1'b0;
  endtask

  // Offers tx_bytes[first +: n] in order; toggle drives data_valid 1,0,1,0...
  task automatic send_bytes(input int first, input int n, input bit toggle);
    int  idx;
    int  budget;
    bit  phase;
    idx    = first;
    budget = 0;
    phase  = 1'b0;
    while (idx < first + n && budget < 8 * n + 64) begin
      data_valid = toggle ? ~phase : 1'b1;
      phase      = ~phase;
      data_in    = tx_bytes[idx];
      #1;
      if (data_valid && data_ready) idx++;
      @(posedge clk_in);
      #1;
      budget++;
    end
    data_valid = 1'b0;
    check("send_budget", idx, first + n);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base_w;
    int base_d;
    int mism;

    reset       = 1'b1;
    frame_start = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    foreach (dut_ram[i]) dut_ram[i] = '0;

    idle(3);
    check("reset_ready", data_ready, 0);
    check("reset_address", ram_address, 0);
    check("reset_data", ram_data_out, 0);
    reset = 1'b0;
    idle(3);
    check("idle_ready", data_ready, 0);

    // First pixel: 0xF8,0x00 lands at the mirrored column 63 of row 0.
    base_w = dut_wcount;
    tx_bytes[0] = 8'hF8;
    tx_bytes[1] = 8'h00;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 2, 1'b0);
    idle(2);
    check("first_write_count", dut_wcount - base_w, 1);
    check("first_write_addr", last_addr, 11'h03F);
`ifdef FRAMEBUFFER_WRITE_BGR_SWAP_EN
    check("first_write_data", last_data, 16'h001F);
`else
    check("first_write_data", last_data, 16'hF800);
`endif

    // Full frame, data_valid held high.
    foreach (tx_bytes[i]) tx_bytes[i] = 8'($urandom);
    base_d = done_count;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 4096, 1'b0);
    idle(3);
    check("full_write_count", frame_widx, 2048);
    check("full_last_addr", last_addr, 11'h7C0);
    check("full_done_count", done_count - base_d, 1);
    check("full_done_latency", done_cyc - last_we_cyc, 1);
    check("full_ready_after", data_ready, 0);
    check("full_addr_p0", addr_log[0], 11'h03F);
    check("full_addr_p1088", addr_log[1088], 11'h47F);
    foreach (ram_cont[i]) ram_cont[i] = dut_ram[i];

    // Same frame with data_valid toggling every cycle.
    foreach (dut_ram[i]) dut_ram[i] = '0;
    base_d = done_count;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 4096, 1'b1);
    idle(3);
    check("toggle_write_count", frame_widx, 2048);
    check("toggle_done_count", done_count - base_d, 1);
    mism = 0;
    foreach (ram_cont[i]) if (dut_ram[i] !== ram_cont[i]) mism++;
    check("toggle_ram_mismatches", mism, 0);

    // Restart after the high byte of pixel 5; the byte offered alongside
    // frame_start is discarded.
    tx_bytes[11] = 8'h12;
    tx_bytes[12] = 8'h34;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 11, 1'b0);
    idle(2);
    check("restart_writes_before", frame_widx, 5);
    pulse_frame_start(1'b1, 8'hAA);
    send_bytes(11, 2, 1'b0);
    idle(2);
    check("restart_writes_after", frame_widx, 1);
    check("restart_addr", last_addr, 11'h03F);
`ifdef FRAMEBUFFER_WRITE_BGR_SWAP_EN
    check("restart_data", last_data, 16'hA222);
`else
    check("restart_data", last_data, 16'h1234);
`endif

    // frame_start during the final WRITE: the write completes, no frame_done.
    base_d = done_count;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 4096, 1'b0);
    check("fs_last_write_we", ram_write_enable, 1);
    pulse_frame_start(1'b0, 8'h00);
    idle(3);
    check("fs_last_write_done", done_count - base_d, 0);
    check("fs_last_write_count", frame_widx, 0);
    check("fs_last_write_ready", data_ready, 1);

    // Reset during the WRITE of pixel 10.
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 22, 1'b0);
    check("rst_write_we_before", ram_write_enable, 1);
    check("rst_write_pixels_before", frame_widx, 10);
    base_w = dut_wcount;
    base_d = done_count;
    reset = 1'b1;
    #1;
    check("rst_write_we", ram_write_enable, 0);
    check("rst_write_clk_en", ram_clk_enable, 0);
    check("rst_write_addr", ram_address, 0);
    check("rst_write_data", ram_data_out, 0);
    check("rst_write_ready", data_ready, 0);
    check("rst_write_done", frame_done, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1;
      data_in    = 8'($urandom);
      tick();
    end
    data_valid = 1'b0;
    check("rst_no_writes", dut_wcount - base_w, 0);
    check("rst_no_done", done_count - base_d, 0);
    tx_bytes[0] = 8'h07;
    tx_bytes[1] = 8'hE0;
    pulse_frame_start(1'b0, 8'h00);
    send_bytes(0, 2, 1'b0);
    idle(2);
    check("rst_resume_count", dut_wcount - base_w, 1);
    check("rst_resume_addr", last_addr, 11'h03F);

    // Randomized traffic: sparse restarts and resets, random valid and data.
    pulse_frame_start(1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 699) == 0);
      frame_start = ($urandom_range(0, 63) == 0);
      data_valid  = ($urandom_range(0, 3) != 0);
      data_in     = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/framebuffer_write.md
FRAMEBUFFER_WRITE -- requirements
Module: framebuffer_write

Interface
REQ-001 Parameter: PIXEL_COUNT, default 2048, pixels per frame (2 halves x 16 rows x 64 columns).
REQ-002 reset  input  1  asynchronous, active-high.
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 frame_start  input  1  one-cycle pulse; restarts the frame at pixel 0.
REQ-005 data_in  input  8  pixel byte stream, RGB565, high byte first.
REQ-006 data_valid  input  1  data_in holds a valid byte.
REQ-007 data_ready  output  1  block accepts a byte this cycle.
REQ-008 ram_address  output  11  {half, row[3:0], ~column[5:0]}.
REQ-009 ram_data_out  output  16  RGB565 pixel written to RAM.
REQ-010 ram_write_enable  output  1  one-cycle write strobe.
REQ-011 ram_clk_enable  output  1  high in every cycle where ram_write_enable is high, low otherwise.
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.

Function
REQ-013 A byte transfer occurs only in a cycle where data_valid and data_ready are both high.
REQ-014 The FSM has four states: IDLE, HI, LO, WRITE.
- IDLE: data_ready=0; frame_start -> HI.
- HI: data_ready=1; transfer latches data_in as pixel[15:8] -> LO.
- LO: data_ready=1; transfer latches data_in as pixel[7:0] -> WRITE.
REQ-015 WRITE lasts exactly one cycle, during which:
- data_ready=0, ram_write_enable=1, ram_clk_enable=1.
- ram_address and ram_data_out are held stable.
REQ-016 Pixel index p (0..PIXEL_COUNT-1) maps as x=p[5:0] and y=p[10:6]; ram_address={y[4], y[3:0], ~x}.
REQ-017 On leaving WRITE, p increments; if p was PIXEL_COUNT-1, frame_done pulses next cycle, p wraps to 0 and the FSM goes to IDLE; otherwise the FSM goes to HI.
REQ-018 frame_start in any state:
- p is cleared to 0 and the FSM goes to HI next cycle.
- Any partially assembled pixel is discarded.
- A WRITE in that same cycle still completes, but does not increment p and does not pulse frame_done.
REQ-019 When frame_start and a byte transfer occur in the same cycle, the byte is discarded.
REQ-020 Latency: ram_write_enable asserts exactly 1 cycle after the low-byte transfer; peak throughput is one pixel per 3 cycles.
REQ-021 data_valid while data_ready=0 has no effect; no byte is lost or duplicated.

Reset
REQ-022 While reset is high:
- The FSM is in IDLE and p=0.
- data_ready, ram_write_enable, ram_clk_enable and frame_done are 0.
- ram_address=11'd0 and ram_data_out=16'd0.
REQ-023 Reset asserted mid-frame aborts the frame without a further RAM write; after release the block waits in IDLE for frame_start.

Configuration
REQ-024 With FRAMEBUFFER_WRITE_BGR_SWAP_EN defined, ram_data_out={pixel[4:0], pixel[10:5], pixel[15:11]} (red and blue swapped).
REQ-025 Without FRAMEBUFFER_WRITE_BGR_SWAP_EN, ram_data_out equals the assembled pixel unchanged; timing is identical in both builds.

Structure
REQ-026 Shared package framebuffer_pkg holds:
- Panel constants: COLUMNS=64, ROWS_PER_HALF=16, PIXEL_COUNT=2048.
- RAM widths: address 11, data 16.
- The FSM state encoding.
REQ-027 One sub-module is natural: framebuffer_address_map, combinational p -> ram_address, shared with the read side.

Verification
REQ-028 Reset, then frame_start, then bytes 0xF8,0x00 -> one WRITE with ram_address=11'h03F and ram_data_out=16'hF800 (16'h001F with BGR swap).
REQ-029 Full frame of 4096 bytes with data_valid held high:
- Exactly 2048 writes; last address is 11'h7C0.
- frame_done pulses once, 1 cycle after the last write.
- data_ready=0 afterwards.
REQ-030 Pixel 1088 (x=0, y=17) -> ram_address=11'h47F.
REQ-031 frame_start after the high byte of pixel 5 -> no write for pixel 5; the next two bytes write to address 11'h03F.
REQ-032 data_valid toggled 1/0 every cycle -> identical RAM contents to the continuous case; no dropped bytes.
REQ-033 Reset pulsed during WRITE of pixel 10:
- All outputs are zero immediately.
- No frame_done pulse.
- No write occurs until frame_start.
